// File: rtl/fetch_seq_if.sv
// Fetch-to-memory/decode bundle: imem address/data, redirect/halt requests, IR handshake, status.
interface fetch_seq_if;
  logic [15:0] im_addr;
  logic [31:0] im_data;
  logic        br_valid;
  logic [15:0] br_target;
  logic        halt;
  logic [31:0] ir;
  logic [15:0] ir_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic        halted;
  logic [15:0] fetch_cnt;

  modport master (
    output im_addr,
    input  im_data,
    input  br_valid,
    input  br_target,
    input  halt,
    output ir,
    output ir_pc,
    output ir_valid,
    input  ir_ready,
    output halted,
    output fetch_cnt
  );

  modport slave (
    input  im_addr,
    output im_data,
    output br_valid,
    output br_target,
    output halt,
    input  ir,
    input  ir_pc,
    input  ir_valid,
    output ir_ready,
    input  halted,
    input  fetch_cnt
  );
endinterface

// File: rtl/fetch_seq.sv
// Instruction fetch sequencer: owns the PC, addresses async-read imem, registers words into a one-entry IR.
// Latency: first IR valid two cycles after reset release, then one per cycle; a redirect costs one bubble.
// Backpressure: IR and PC hold while ir_valid && !ir_ready; the next word loads in the accepting cycle.
module fetch_seq #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input logic         clk,
  input logic         rst,
  fetch_seq_if.master fetch
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [15:0] ir_pc_q, ir_pc_d;
  logic        ir_valid_q, ir_valid_d;
  logic        halted_q, halted_d;
  logic [15:0] cnt_q, cnt_d;

  logic accept;
  logic load_ok;

  assign accept  = ir_valid_q && fetch.ir_ready;
  assign load_ok = !ir_valid_q || fetch.ir_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      ir_q       <= 32'h0;
      ir_pc_q    <= 16'h0;
      ir_valid_q <= 1'b0;
      halted_q   <= 1'b0;
      cnt_q      <= 16'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
      halted_q   <= halted_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    halted_d   = halted_q;

    // Decode took the word even if it is being flushed this cycle, so it still counts.
    cnt_d = cnt_q;
    if (accept && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end

    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (fetch.halt) begin
          state_d    = ST_HALT;
          halted_d   = 1'b1;
          ir_valid_d = 1'b0;
        end else if (fetch.br_valid) begin
          pc_d       = fetch.br_target;
          ir_valid_d = 1'b0;
        end else if (load_ok) begin
          ir_d       = fetch.im_data;
          ir_pc_d    = pc_q;
          ir_valid_d = 1'b1;
          pc_d       = pc_q + 16'd1;
        end
      end
      ST_HALT: begin
        ir_valid_d = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign fetch.im_addr   = pc_q;
  assign fetch.ir        = ir_q;
  assign fetch.ir_pc     = ir_pc_q;
  assign fetch.ir_valid  = ir_valid_q;
  assign fetch.halted    = halted_q;
  assign fetch.fetch_cnt = cnt_q;

endmodule
